ppm_decoder: RTL and testbench

PPM_DECODER -- requirements
Module: ppm_decoder

---
 rtl/ppm_pkg.sv | 23 ++
 rtl/ppm_decoder_pulse_sync.sv | 29 ++
 rtl/ppm_decoder.sv | 182 ++++++++++++++++++
 tb/tb_ppm_decoder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ppm_pkg.sv
// Shared PPM line constants, decoder state encoding and symbol-period helper.
// The encoder side imports the same defaults so both ends agree on timing.
package ppm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int unsigned PPM_PULSE_CT = 7500;
  localparam int unsigned PPM_N_MOD    = 2;
  localparam int unsigned PPM_L        = 10000;
  localparam int unsigned PPM_N_PKT    = 8;
  localparam int unsigned PPM_PRE_CT   = 4;
  localparam int unsigned PPM_TOL      = 1000;

  // Symbol period: 2**n_mod slots of l cycles each.
  function automatic int unsigned sym_len(input int unsigned n_mod, input int unsigned l);
    return (32'd1 << n_mod) * l;
  endfunction

endpackage

// File: rtl/ppm_decoder_pulse_sync.sv
// Two-flop synchronizer for the optical receiver line plus rising-edge detect.
module pulse_sync
  import ppm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic rise_c
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= pulse_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise_c = sync & ~prev;

endmodule

// File: rtl/ppm_decoder.sv
// PPM packet decoder: preamble lock, per-symbol window timing and payload
// assembly from rising edges of the synchronized receiver line.
module ppm_decoder
  import ppm_pkg::*;
#(
  parameter int unsigned PULSE_CT = PPM_PULSE_CT,
  parameter int unsigned N_MOD    = PPM_N_MOD,
  parameter int unsigned L        = PPM_L,
  parameter int unsigned N_PKT    = PPM_N_PKT,
  parameter int unsigned PRE_CT   = PPM_PRE_CT,
  parameter int unsigned TOL      = PPM_TOL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic [N_PKT-1:0] data,
  output logic             avail,
  output logic             err
);

  localparam int unsigned M     = 32'd1 << N_MOD;
  localparam int unsigned SYM   = sym_len(N_MOD, L);
  localparam int unsigned N_SYM = N_PKT / N_MOD;
  localparam int unsigned TW    = $clog2(SYM + TOL + 1);
  localparam int unsigned CW    = $clog2(PRE_CT + 1);
  localparam int unsigned IW    = $clog2(N_SYM + 1);
  localparam bit          CFG_OK = (PULSE_CT < L) && (TOL > 0) && (2 * TOL < L)
                                   && (N_PKT % N_MOD == 0);

  // Timer holds elapsed-1 at the cycle an edge is presented, hence the -1 bounds.
  localparam logic [TW-1:0] PRE_LO  = TW'(SYM - TOL - 1);
  localparam logic [TW-1:0] PRE_HI  = TW'(SYM + TOL - 1);
  localparam logic [TW-1:0] LEAD    = TW'(SYM - TOL - 1);
  localparam logic [TW-1:0] WIN_END = TW'(SYM - 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("ppm_decoder: inconsistent PULSE_CT/L/TOL/N_PKT/N_MOD");
  end

  logic rise_c;

  pulse_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .pulse_in(pulse_in),
    .rise_c  (rise_c)
  );

  state_t             state, state_n;
  logic [TW-1:0]      timer, timer_n;
  logic [CW-1:0]      pcnt, pcnt_n;
  logic [IW-1:0]      sidx, sidx_n;
  logic               lead, lead_n;
  logic               got, got_n;
  logic [N_PKT-1:0]   shreg, shreg_n;
  logic               done, done_n;
  logic               err_n;

  logic [TW-1:0]      t_c;
  logic               win_c;
  logic               hit_c;
  logic [N_MOD-1:0]   val_c;

  // During the lead-in the window opens only on the cycle the countdown hits zero.
  assign t_c   = lead ? '0 : timer;
  assign win_c = !lead || (timer == '0);

  // Slot accept bands [i*L, i*L+2*TOL] by comparison against constants.
  always_comb begin
    hit_c = 1'b0;
    val_c = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if ((t_c >= TW'(i * L)) && (t_c <= TW'(i * L + 2 * TOL))) begin
        hit_c = 1'b1;
        val_c = N_MOD'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      pcnt  <= '0;
      sidx  <= '0;
      lead  <= 1'b0;
      got   <= 1'b0;
      shreg <= '0;
      done  <= 1'b0;
      data  <= '0;
      avail <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      pcnt  <= pcnt_n;
      sidx  <= sidx_n;
      lead  <= lead_n;
      got   <= got_n;
      shreg <= shreg_n;
      done  <= done_n;
      err   <= err_n;
      avail <= done;
      if (done) data <= shreg;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    pcnt_n  = pcnt;
    sidx_n  = sidx;
    lead_n  = lead;
    got_n   = got;
    shreg_n = shreg;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (rise_c) begin
          state_n = PRE;
          pcnt_n  = CW'(1);
          timer_n = '0;
        end
      end
      PRE: begin
        if (rise_c) begin
          timer_n = '0;
          if ((timer >= PRE_LO) && (timer <= PRE_HI)) begin
            if (pcnt == CW'(PRE_CT - 1)) begin
              state_n = DATA;
              sidx_n  = '0;
              lead_n  = 1'b1;
              got_n   = 1'b0;
              timer_n = LEAD;
            end else begin
              pcnt_n = pcnt + 1'b1;
            end
          end else begin
            pcnt_n = CW'(1);
          end
        end else if (timer == PRE_HI) begin
          state_n = IDLE;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DATA: begin
        if (lead) begin
          lead_n  = (timer != '0);
          timer_n = (timer == '0) ? TW'(1) : timer - 1'b1;
        end else if (timer == WIN_END) begin
          timer_n = '0;
          got_n   = 1'b0;
        end else begin
          timer_n = timer + 1'b1;
        end
        if (rise_c) begin
          if (!win_c || !hit_c || got) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            shreg_n = N_PKT'({shreg, val_c});
            if (sidx == IW'(N_SYM - 1)) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              sidx_n = sidx + 1'b1;
              got_n  = 1'b1;
            end
          end
        end else if (!lead && (timer == WIN_END) && !got) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ppm_decoder.sv
// Directed PPM packets with a scoreboard of expected avail/err strobes.
module tb_ppm_decoder;

  localparam int PULSE_CT = 12;
  localparam int N_MOD    = 2;
  localparam int L        = 20;
  localparam int N_PKT    = 8;
  localparam int PRE_CT   = 4;
  localparam int TOL      = 3;
  localparam int SYM      = 80;
  localparam int LAT      = 4;

  localparam int M_NONE  = 0;
  localparam int M_OK    = 1;
  localparam int M_ERR0  = 2;
  localparam int M_MISS  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pulse_in = 1'b0;
  logic [N_PKT-1:0] data;
  logic             avail;
  logic             err;

  ppm_decoder #(
    .PULSE_CT(PULSE_CT), .N_MOD(N_MOD), .L(L), .N_PKT(N_PKT), .PRE_CT(PRE_CT), .TOL(TOL)
  ) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .data(data), .avail(avail), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         c;
  } ev_t;

  ev_t        exp_q[$];
  int         total = 0;
  int         bad = 0;
  bit         finishing = 1'b0;
  logic [7:0] last_good = 8'h00;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Preamble (optionally preceded by a mis-spaced start), then n_data symbols.
  task automatic send_pkt(input logic [7:0] payload, input int off, input int n_data,
                          input int gap, input bit glitch, input int mode);
    int sched[$];
    int base, p0, plast, t0;
    logic [N_MOD-1:0] v;
    base = cyc;
    p0 = gap;
    t0 = 0;
    if (glitch) begin
      sched.push_back(gap);
      sched.push_back(gap + SYM);
      p0 = gap + SYM + 60;
    end
    for (int i = 0; i < PRE_CT; i++) sched.push_back(p0 + i * SYM);
    plast = p0 + (PRE_CT - 1) * SYM;
    for (int k = 0; k < n_data; k++) begin
      v = payload[N_PKT-1-N_MOD*k -: N_MOD];
      sched.push_back(plast + (k + 1) * SYM + int'(v) * L + off);
      if (k == 0) t0 = sched[$];
    end
    case (mode)
      M_OK: begin
        exp_q.push_back('{1'b0, payload, base + sched[$] + LAT});
        last_good = payload;
      end
      M_ERR0: exp_q.push_back('{1'b1, last_good, base + t0 + 3});
      M_MISS: exp_q.push_back('{1'b1, last_good,
                                base + plast + 3 + (SYM - TOL) + (n_data + 1) * SYM - 1});
      default: ;
    endcase
    for (int i = 0; i < sched.size(); i++) begin
      while (cyc - base < sched[i]) @(negedge clk);
      pulse_in = 1'b1;
      repeat (PULSE_CT) @(negedge clk);
      pulse_in = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle(4);
    rst = 1'b0;
    idle(5);
    send_pkt(8'hC9, 0, 4, 8, 1'b0, M_OK);   idle(200);
    send_pkt(8'h1E, -3, 4, 8, 1'b0, M_OK);  idle(200);
    send_pkt(8'hC9, 3, 4, 8, 1'b0, M_OK);   idle(200);
    send_pkt(8'h5A, 0, 4, 8, 1'b0, M_OK);   idle(200);
    send_pkt(8'hC9, 4, 1, 8, 1'b0, M_ERR0); idle(300);
    send_pkt(8'h1B, 0, 4, 8, 1'b1, M_OK);   idle(200);
    send_pkt(8'hE4, 0, 2, 8, 1'b0, M_MISS); idle(400);
    send_pkt(8'h3C, 0, 1, 8, 1'b0, M_NONE);
    idle(80);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    last_good = 8'h00;
    idle(20);
    send_pkt(8'hA5, 0, 4, 8, 1'b0, M_OK);   idle(20);
    send_pkt(8'h00, 0, 4, 8, 1'b0, M_OK);
    send_pkt(8'hFF, 0, 4, 8, 1'b0, M_OK);   idle(200);
    finishing = 1'b1;
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  bit  rst_q = 1'b0;
  bit  avail_q = 1'b0;
  bit  err_q = 1'b0;
  ev_t mon_ev;

  always @(negedge clk) begin
    if (cyc > 40000) begin
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "watchdog");
    end
    if (rst && rst_q) begin
      chk("reset_data", int'(data), 0);
      chk("reset_avail", int'(avail), 0);
      chk("reset_err", int'(err), 0);
    end else if (!rst) begin
      if (avail_q) chk("avail_width", int'(avail), 0);
      if (err_q) chk("err_width", int'(err), 0);
      if (avail || err) begin
        chk("avail_err_exclusive", int'(avail && err), 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe avail=%0d err=%0d data=%0h cycle=%0d",
                   avail, err, data, cyc);
        end else begin
          mon_ev = exp_q.pop_front();
          chk("strobe_kind_err", int'(err), int'(mon_ev.is_err));
          chk("strobe_data", int'(data), int'(mon_ev.d));
          chk("strobe_cycle", cyc, mon_ev.c);
        end
      end
    end
    rst_q   = rst;
    avail_q = avail;
    err_q   = err;
    if (finishing) begin
      chk("missing_strobes", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

endmodule
